cram_bk_arbiter: RTL and testbench
==================================

Name: cram_bk_arbiter

Overview:
- Shares the single byte-wide cartridge RAM port between two requesters:
  - the CPU-side mapper path, which has absolute priority;
  - the backup-RAM save/load engine (SD image streaming), which moves 16-bit words.
- Sits between the active mapper (cram_addr/cram_do/ram_enabled) and the cart RAM.
- Splits each engine word into two byte accesses, scheduled only in cycles the CPU does not own.

Parameters:
- ADDR_W, 17: cart RAM byte address width (128 KiB).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce_cpu  in  1  CPU clock enable; the CPU owns the RAM port in every cycle where this is high
- cpu_addr  in  ADDR_W  CPU-side RAM byte address (mapper cram_addr)
- cpu_wr  in  1  CPU write strobe to the cart RAM window
- cpu_di  in  8  CPU write data
- ram_enabled  in  1  mapper RAM-enable; gates CPU writes only
- cpu_do  out  8  last RAM byte read on behalf of the CPU
- bk_en  in  1  backup RAM present/allowed
- bk_req  in  1  engine request level, 4-phase
- bk_wr  in  1  1 = write word, 0 = read word; sampled with bk_req
- bk_addr  in  ADDR_W-1  word address
- bk_din  in  16  write word
- bk_dout  out  16  read word
- bk_ack  out  1  4-phase acknowledge
- bk_dirty  out  1  RAM modified since last clear (optional feature)
- bk_clr_dirty  in  1  dirty-flag clear pulse (optional feature)
- ram_addr  out  ADDR_W  RAM byte address
- ram_we  out  1  RAM write enable
- ram_d  out  8  RAM write data
- ram_q  in  8  RAM read data, one-cycle synchronous latency

Behaviour:
- Reset values (async, reset_n low):
  - state = IDLE; bk_ack = 0; bk_dout = 0; cpu_do = 0xFF; bk_dirty = 0.
  - Reset mid-transaction aborts it immediately; ram_we drops the same instant.
- Port ownership each cycle: the engine owns the port iff state ∈ {LO, HI} and ce_cpu = 0; otherwise the CPU owns it.
- CPU-owned cycle:
  - ram_addr = cpu_addr; ram_d = cpu_di.
  - ram_we = ce_cpu & cpu_wr & ram_enabled.
- Engine-owned cycle:
  - ram_addr = {bk_addr_latched, 0} in LO, {bk_addr_latched, 1} in HI.
  - ram_we = wr_latched; ram_d = low byte in LO, high byte in HI.
  - Engine writes ignore ram_enabled.
- cpu_do: registers ram_q in every cycle whose previous cycle was CPU-owned; holds otherwise.
- FSM:
  - IDLE: if bk_req, latch bk_wr/bk_addr/bk_din.
    - If bk_en = 0: go to DONE with bk_dout = 0xFFFF and no RAM access.
    - Else go to LO.
  - LO: if ce_cpu, stall. Else access low byte, go to HI.
  - HI: if ce_cpu, stall. Else access high byte, go to CAP.
  - CAP: one cycle, then DONE.
  - DONE: bk_ack = 1. When bk_req = 0, deassert bk_ack and go to IDLE.
- Read capture: bk_dout[7:0] ← ram_q in the cycle immediately after the LO access, even if HI is stalled by ce_cpu. bk_dout[15:8] ← ram_q in CAP.
- Minimum latency (no contention): bk_req rises → bk_ack high 4 clocks later.
- Stalls are unbounded while ce_cpu stays high; no engine access ever overlaps a ce_cpu cycle.
- bk_req dropping before ack: the transaction still completes. DONE then releases immediately, with one ack cycle.
- A bk_req held high after release starts a new transaction only after the IDLE cycle.
- bk_addr all-ones: byte addresses 0x1FFFE/0x1FFFF; no wrap within a word.

Optional Feature:
- CRAM_BK_DIRTY_EN defined:
  - bk_dirty sets on any CPU-owned cycle with ram_we = 1.
  - It clears on a bk_clr_dirty pulse.
  - A simultaneous set and clear leaves it set.
  - Engine writes never set it.
- Undefined: bk_dirty tied 0, bk_clr_dirty ignored, no flag register.

Test Plan:
- Engine read, no contention: RAM 0x0040 = 0x34, 0x0041 = 0x12; bk_addr = 0x0020 read → bk_ack after 4 clocks, bk_dout = 0x1234.
- Engine write, ce_cpu high in LO and HI cycles: bk_din = 0xBEEF to word 0x0010 → each access delayed 1 clock; RAM 0x20 = 0xEF, 0x21 = 0xBE; no ram_we during ce_cpu unless cpu_wr.
- ce_cpu pulse in the cycle right after LO during a read: bk_dout[7:0] is still the LO byte, not the CPU-address byte.
- CPU write with ram_enabled = 0, then = 1 (addr 0x00100, 0x5A) → first no ram_we; second writes 0x5A; bk_dirty = 1 (feature on); bk_clr_dirty → 0.
- bk_en = 0, read request → bk_dout = 0xFFFF, no RAM access; bk_ack held until bk_req low.
- reset_n low while in HI → ram_we 0, bk_ack 0, state IDLE immediately; after release, a new request completes normally.

Source files
------------

// File: rtl/cram_bk_arbiter.sv
// Cart RAM port arbiter: CPU mapper path has absolute priority, the backup-RAM
// engine moves 16-bit words as two byte accesses in free cycles. Optional: CRAM_BK_DIRTY_EN.
module cram_bk_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_cpu,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_di,
  input  logic              ram_enabled,
  output logic [7:0]        cpu_do,
  input  logic              bk_en,
  input  logic              bk_req,
  input  logic              bk_wr,
  input  logic [ADDR_W-2:0] bk_addr,
  input  logic [15:0]       bk_din,
  output logic [15:0]       bk_dout,
  output logic              bk_ack,
  output logic              bk_dirty,
  input  logic              bk_clr_dirty,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_d,
  input  logic [7:0]        ram_q
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_CAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic [15:0]       bk_dout_q, bk_dout_d;
  logic              bk_ack_q, bk_ack_d;
  logic [7:0]        cpu_do_q, cpu_do_d;
  logic              cpu_own_q, cpu_own_d;
  logic              lo_cap_q, lo_cap_d;
  logic              eng_own;

  assign eng_own = ((state_q == ST_LO) || (state_q == ST_HI)) && !ce_cpu;

  // RAM port mux; combinational so a reset or a ce_cpu cycle takes the port at once
  always_comb begin
    if (eng_own) begin
      ram_addr = {addr_q, (state_q == ST_HI)};
      ram_we   = wr_q;
      ram_d    = (state_q == ST_HI) ? din_q[15:8] : din_q[7:0];
    end else begin
      ram_addr = cpu_addr;
      ram_we   = ce_cpu & cpu_wr & ram_enabled;
      ram_d    = cpu_di;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    din_d     = din_q;
    bk_dout_d = bk_dout_q;
    lo_cap_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bk_req) begin
          wr_d   = bk_wr;
          addr_d = bk_addr;
          din_d  = bk_din;
          if (bk_en) begin
            state_d = ST_LO;
          end else begin
            state_d   = ST_DONE;
            bk_dout_d = 16'hFFFF;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LO: begin
        if (!ce_cpu) begin
          state_d  = ST_HI;
          lo_cap_d = ~wr_q;
        end else begin
          state_d = ST_LO;
        end
      end
      ST_HI: begin
        if (!ce_cpu) begin
          state_d = ST_CAP;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_CAP: begin
        state_d = ST_DONE;
        if (!wr_q) begin
          bk_dout_d[15:8] = ram_q;
        end else begin
          bk_dout_d[15:8] = bk_dout_q[15:8];
        end
      end
      ST_DONE: begin
        if (!bk_req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // low byte lands one cycle after the LO access, even while HI is stalled
    if (lo_cap_q) begin
      bk_dout_d[7:0] = ram_q;
    end else begin
      bk_dout_d[7:0] = bk_dout_d[7:0];
    end
  end

  assign bk_ack_d  = (state_d == ST_DONE);
  assign cpu_own_d = ~eng_own;
  assign cpu_do_d  = cpu_own_q ? ram_q : cpu_do_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= 16'h0000;
      bk_dout_q <= 16'h0000;
      bk_ack_q  <= 1'b0;
      cpu_do_q  <= 8'hFF;
      cpu_own_q <= 1'b1;
      lo_cap_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      bk_dout_q <= bk_dout_d;
      bk_ack_q  <= bk_ack_d;
      cpu_do_q  <= cpu_do_d;
      cpu_own_q <= cpu_own_d;
      lo_cap_q  <= lo_cap_d;
    end
  end

  assign bk_dout = bk_dout_q;
  assign bk_ack  = bk_ack_q;
  assign cpu_do  = cpu_do_q;

`ifdef CRAM_BK_DIRTY_EN
  logic dirty_q, dirty_d;

  // set wins over a simultaneous clear; engine cycles never mark the image dirty
  always_comb begin
    if (!eng_own && ram_we) begin
      dirty_d = 1'b1;
    end else if (bk_clr_dirty) begin
      dirty_d = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dirty_q <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
    end
  end

  assign bk_dirty = dirty_q;
`else
  logic unused_clr_dirty;
  assign unused_clr_dirty = bk_clr_dirty;
  assign bk_dirty         = 1'b0;
`endif

endmodule

// File: tb/tb_cram_bk_arbiter.sv
// Scoreboard bench for cram_bk_arbiter: directed cases plus randomized engine
// traffic under random CPU contention, checked against a byte-array RAM model.
`timescale 1ns/1ps
module tb_cram_bk_arbiter;
  localparam int ADDR_W = 17;
  localparam int MEM_SZ = 1 << ADDR_W;
`ifdef CRAM_BK_DIRTY_EN
  localparam logic DIRTY_ON = 1'b1;
`else
  localparam logic DIRTY_ON = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ce_cpu = 1'b0, cpu_wr = 1'b0, ram_enabled = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]  cpu_di = 8'h00;
  logic [7:0]  cpu_do;
  logic bk_en = 1'b0, bk_req = 1'b0, bk_wr = 1'b0, bk_clr_dirty = 1'b0;
  logic [ADDR_W-2:0] bk_addr = '0;
  logic [15:0] bk_din = 16'h0000;
  logic [15:0] bk_dout;
  logic bk_ack, bk_dirty;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_we;
  logic [7:0] ram_d;
  logic [7:0] ram_q = 8'h00;

  logic [7:0] mem     [0:MEM_SZ-1];
  logic [7:0] ref_mem [0:MEM_SZ-1];
  bit   mem_init_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit cpu_rand = 1'b0;
  bit txn_bk_off = 1'b0;
  bit pat [0:31];

  typedef struct {
    bit          chk_dout;
    logic [15:0] dout;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  cram_bk_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce_cpu), .cpu_addr(cpu_addr),
    .cpu_wr(cpu_wr), .cpu_di(cpu_di), .ram_enabled(ram_enabled), .cpu_do(cpu_do),
    .bk_en(bk_en), .bk_req(bk_req), .bk_wr(bk_wr), .bk_addr(bk_addr), .bk_din(bk_din),
    .bk_dout(bk_dout), .bk_ack(bk_ack), .bk_dirty(bk_dirty), .bk_clr_dirty(bk_clr_dirty),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37) ^ (a >> 8) ^ (a >> 16));
  endfunction

  // synchronous cart RAM, one-cycle read latency
  always @(posedge clk_sys) begin
    if (!mem_init_done) begin
      for (int i = 0; i < MEM_SZ; i++) mem[i] <= init_byte(i);
      mem_init_done <= 1'b1;
    end else begin
      ram_q <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_d;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // monitor: CPU priority every ce_cpu cycle, scoreboard pop on each ack rise
  bit   mon_active = 1'b0;
  int   mon_cnt = 0;
  bit   req_prev = 1'b0, ack_prev = 1'b0;
  exp_t e_m;
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      mon_active = 1'b0;
      mon_cnt    = 0;
      req_prev   = 1'b0;
      ack_prev   = 1'b0;
    end else begin
      if (ce_cpu)
        chk("cpu_port", {ram_we, ram_addr, ram_d}, {cpu_wr & ram_enabled, cpu_addr, cpu_di});
      if (txn_bk_off && !ce_cpu) chk("no_access", {31'd0, ram_we}, 32'd0);
      if (mon_active) mon_cnt++;
      if (bk_req && !req_prev && !mon_active) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
      if (bk_ack && !ack_prev) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL ack_unexpected: got ack with empty scoreboard");
        end else begin
          e_m = sb_q.pop_front();
          chk("latency", mon_cnt, e_m.lat);
          if (e_m.chk_dout) chk("bk_dout", {16'd0, bk_dout}, {16'd0, e_m.dout});
        end
        mon_active = 1'b0;
      end
      req_prev = bk_req;
      ack_prev = bk_ack;
    end
  end

  task automatic fill_pat(input int pct);
    for (int i = 0; i < 32; i++) pat[i] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic zero_pat();
    for (int i = 0; i < 32; i++) pat[i] = 1'b0;
  endtask

  // request cycle, then two cycles without ce_cpu (LO, HI), then the capture cycle
  function automatic int model_lat();
    int free_n = 0;
    for (int i = 1; i < 64; i++) begin
      if (i >= 32 || !pat[i]) free_n++;
      if (free_n == 2) return i + 2;
    end
    return -1;
  endfunction

  task automatic drive_cycle(input bit c);
    ce_cpu = c;
    if (cpu_rand) begin
      cpu_addr    = 17'h10000 + 17'($urandom_range(0, 32'hFFEF));
      cpu_wr      = 1'($urandom_range(0, 1));
      ram_enabled = 1'($urandom_range(0, 1));
      cpu_di      = 8'($urandom);
    end
    if (c && cpu_wr && ram_enabled) ref_mem[cpu_addr] = cpu_di;
  endtask

  task automatic cpu_cycle(input bit c, input bit w, input bit en, input logic [16:0] a,
                           input logic [7:0] d, input bit clr);
    @(posedge clk_sys); #1;
    cpu_addr = a; cpu_wr = w; ram_enabled = en; cpu_di = d; bk_clr_dirty = clr;
    drive_cycle(c);
  endtask

  task automatic eng_txn(input bit wr, input logic [15:0] waddr, input logic [15:0] din,
                         input bit en, input bit early, input int hold);
    exp_t e;
    int i;
    bit seen;
    logic [16:0] ba;
    ba = {waddr, 1'b0};
    e.lat = en ? model_lat() : 1;
    e.chk_dout = !en || !wr;
    e.dout = !en ? 16'hFFFF : {ref_mem[ba + 17'd1], ref_mem[ba]};
    if (en && wr) begin
      ref_mem[ba]         = din[7:0];
      ref_mem[ba + 17'd1] = din[15:8];
    end
    sb_q.push_back(e);
    @(posedge clk_sys); #1;
    txn_bk_off = !en;
    bk_en = en; bk_wr = wr; bk_addr = waddr; bk_din = din; bk_req = 1'b1;
    drive_cycle(pat[0]);
    seen = 1'b0;
    i = 0;
    while (!seen && i < 200) begin
      @(posedge clk_sys); #1;
      i++;
      if (early && i == 1) bk_req = 1'b0;
      if (bk_ack) seen = 1'b1;
      else drive_cycle(i < 32 ? pat[i] : 1'b0);
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: got no ack after %0d cycles, required ack", i);
    end
    ce_cpu = 1'b0;
    cpu_wr = 1'b0;
    repeat (hold) begin
      @(posedge clk_sys); #1;
      chk("ack_hold", {31'd0, bk_ack}, 32'd1);
    end
    bk_req = 1'b0;
    @(posedge clk_sys); #1;
    chk("ack_release", {31'd0, bk_ack}, 32'd0);
    txn_bk_off = 1'b0;
  endtask

  initial begin
    int nbad;
    bit w, en, early;
    logic [15:0] a;
    for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = init_byte(i);
    #12;
    chk("rst_ack", {31'd0, bk_ack}, 32'd0);
    chk("rst_dout", {16'd0, bk_dout}, 32'd0);
    chk("rst_cpu_do", {24'd0, cpu_do}, 32'hFF);
    chk("rst_dirty", {31'd0, bk_dirty}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;

    // engine read without contention
    cpu_cycle(1'b1, 1'b1, 1'b1, 17'h00040, 8'h34, 1'b0);
    cpu_cycle(1'b1, 1'b1, 1'b1, 17'h00041, 8'h12, 1'b0);
    cpu_cycle(1'b0, 1'b0, 1'b0, 17'h00041, 8'h00, 1'b0);
    zero_pat();
    eng_txn(1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 0);

    // engine write with ce_cpu in the LO and HI cycles
    zero_pat();
    pat[1] = 1'b1; pat[3] = 1'b1;
    eng_txn(1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b0, 0);
    chk("wr_lo_byte", {24'd0, mem[17'h20]}, 32'hEF);
    chk("wr_hi_byte", {24'd0, mem[17'h21]}, 32'hBE);

    // ce_cpu right after LO must not disturb the low byte
    cpu_cycle(1'b1, 1'b1, 1'b1, 17'h00300, 8'hA5, 1'b0);
    cpu_cycle(1'b1, 1'b1, 1'b1, 17'h00060, 8'h77, 1'b0);
    cpu_cycle(1'b1, 1'b1, 1'b1, 17'h00061, 8'h66, 1'b0);
    cpu_cycle(1'b0, 1'b0, 1'b0, 17'h00300, 8'h00, 1'b0);
    zero_pat();
    pat[2] = 1'b1;
    eng_txn(1'b0, 16'h0030, 16'h0000, 1'b1, 1'b0, 0);

    // CPU write gating, read-back and dirty flag
    cpu_cycle(1'b0, 1'b0, 1'b0, 17'h00100, 8'h00, 1'b1);
    cpu_cycle(1'b1, 1'b1, 1'b0, 17'h00100, 8'h5A, 1'b0);
    cpu_cycle(1'b0, 1'b0, 1'b0, 17'h00100, 8'h00, 1'b0);
    chk("blocked_write", {24'd0, mem[17'h100]}, {24'd0, ref_mem[17'h100]});
    chk("dirty_blocked", {31'd0, bk_dirty}, 32'd0);
    cpu_cycle(1'b1, 1'b1, 1'b1, 17'h00100, 8'h5A, 1'b0);
    cpu_cycle(1'b0, 1'b0, 1'b0, 17'h00100, 8'h00, 1'b0);
    chk("cpu_write", {24'd0, mem[17'h100]}, 32'h5A);
    chk("dirty_set", {31'd0, bk_dirty}, {31'd0, DIRTY_ON});
    cpu_cycle(1'b1, 1'b0, 1'b0, 17'h00100, 8'h00, 1'b0);
    cpu_cycle(1'b0, 1'b0, 1'b0, 17'h00100, 8'h00, 1'b0);
    cpu_cycle(1'b0, 1'b0, 1'b0, 17'h00100, 8'h00, 1'b0);
    chk("cpu_do", {24'd0, cpu_do}, 32'h5A);
    cpu_cycle(1'b0, 1'b0, 1'b0, 17'h00100, 8'h00, 1'b1);
    cpu_cycle(1'b0, 1'b0, 1'b0, 17'h00100, 8'h00, 1'b0);
    chk("dirty_clr", {31'd0, bk_dirty}, 32'd0);
    cpu_cycle(1'b1, 1'b1, 1'b1, 17'h00101, 8'h11, 1'b1);
    cpu_cycle(1'b0, 1'b0, 1'b0, 17'h00101, 8'h00, 1'b0);
    chk("dirty_set_wins", {31'd0, bk_dirty}, {31'd0, DIRTY_ON});
    cpu_cycle(1'b0, 1'b0, 1'b0, 17'h00101, 8'h00, 1'b1);
    cpu_cycle(1'b0, 1'b0, 1'b0, 17'h00101, 8'h00, 1'b0);
    zero_pat();
    eng_txn(1'b1, 16'h0200, 16'h4321, 1'b1, 1'b0, 0);
    chk("dirty_engine", {31'd0, bk_dirty}, 32'd0);

    // backup RAM absent: 0xFFFF, no access, ack held until request drops
    zero_pat();
    eng_txn(1'b0, 16'h0050, 16'h0000, 1'b0, 1'b0, 3);

    // early request drop: still completes with a single ack cycle
    zero_pat();
    eng_txn(1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 0);

    // top word: no wrap to address 0
    zero_pat();
    eng_txn(1'b1, 16'hFFFF, 16'h9A8B, 1'b1, 1'b0, 0);
    eng_txn(1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    chk("top_lo", {24'd0, mem[17'h1FFFE]}, 32'h8B);
    chk("top_hi", {24'd0, mem[17'h1FFFF]}, 32'h9A);
    chk("no_wrap", {24'd0, mem[0]}, {24'd0, ref_mem[0]});

    // reset while in HI aborts the access immediately
    cpu_addr = 17'h00500; cpu_wr = 1'b0; ce_cpu = 1'b0; bk_en = 1'b1;
    @(posedge clk_sys); #1;
    bk_wr = 1'b1; bk_addr = 16'h1000; bk_din = 16'hC3D4; bk_req = 1'b1;
    @(posedge clk_sys); #1;
    chk("lo_access", {ram_we, ram_addr, ram_d}, {1'b1, 17'h02000, 8'hD4});
    ref_mem[17'h02000] = 8'hD4;
    @(posedge clk_sys); #1;
    chk("hi_access", {ram_we, ram_addr, ram_d}, {1'b1, 17'h02001, 8'hC3});
    reset_n = 1'b0;
    bk_req = 1'b0;
    #1;
    chk("rst_mid_we", {31'd0, ram_we}, 32'd0);
    chk("rst_mid_ack", {31'd0, bk_ack}, 32'd0);
    chk("rst_mid_idle", {15'd0, ram_addr}, 32'h00500);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    zero_pat();
    eng_txn(1'b0, 16'h1000, 16'h0000, 1'b1, 1'b0, 0);

    // randomized traffic under CPU contention
    cpu_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      w     = 1'($urandom_range(0, 1));
      en    = ($urandom_range(0, 9) != 0);
      early = ($urandom_range(0, 7) == 0);
      a     = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 63)) : 16'($urandom_range(0, 32'h7FFF));
      fill_pat(35);
      eng_txn(w, a, 16'($urandom), en, early, early ? 0 : $urandom_range(0, 2));
    end
    cpu_rand = 1'b0;
    ce_cpu = 1'b0;
    cpu_wr = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    nbad = 0;
    for (int i = 0; i < MEM_SZ; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk("mem_image", nbad, 32'd0);
    chk("sb_drain", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
